aclk_ctrl_multi: RTL
====================

Name: aclk_ctrl_multi

Overview:
- Second-generation alarm-clock front-panel controller FSM.
- Sequences keypad digit entry, shows the current time or a stored alarm, and issues load strobes to the time and alarm registers.
- Adds over the first generation:
  - parametrised digit count and entry timeout;
  - NUM_ALARMS selectable alarm slots;
  - entry-complete checking;
  - one_second is a synchronous tick enable, not a second clock.
- Sits between the keypad scanner and the time/alarm register bank and display mux.

Parameters:
NUM_DIGITS, 4, digits in a full entry (1..8)
TIMEOUT_SEC, 10, one_second ticks of inactivity before entry is abandoned (1..255)
NUM_ALARMS, 2, number of alarm slots (1..16)
KEY_W, 4, keypad code width
NO_KEY, 10, key code meaning "no key pressed"

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; sampled on rising clk
one_second  in  1  single-cycle tick enable, clk domain, once per second
alarm_button  in  1  level, alarm show/set request
time_button  in  1  level, time set request
alarm_sel  in  AW=max(1,clog2(NUM_ALARMS))  alarm slot select
key  in  KEY_W  current key code, NO_KEY when idle
shift  out  1  shift current key into the entry buffer
show_new_time  out  1  display the entry buffer
show_a  out  1  display alarm slot alarm_idx
load_new_a  out  1  write entry buffer into alarm slot alarm_idx
load_new_c  out  1  write entry buffer into current time
reset_count  out  1  clear seconds prescaler (with load_new_c)
alarm_idx  out  AW  registered slot index
digit_cnt  out  clog2(NUM_DIGITS+1)  digits shifted so far

Behaviour:
- Reset (synchronous): pstate=SHOW_TIME; timer=0; digit_cnt=0; alarm_idx=0. All 1-bit outputs are 0 the cycle after reset is sampled high. reset has priority over every other input.
- State register updates every clk. Outputs are Moore, decoded from pstate:
  - shift = KEY_STORED
  - show_new_time = KEY_STORED | KEY_WAITED | KEY_ENTRY | SET_ALARM | SET_TIME
  - show_a = SHOW_ALARM
  - load_new_a = SET_ALARM
  - load_new_c = reset_count = SET_TIME
- Timer:
  - Cleared on any state change and in every state other than KEY_WAITED and KEY_ENTRY.
  - In those two states it increments on one_second and saturates at TIMEOUT_SEC.
  - tmo = (timer == TIMEOUT_SEC).
- digit_cnt:
  - Cleared in SHOW_TIME.
  - Increments by 1 in each KEY_STORED cycle and never exceeds NUM_DIGITS.
- Transitions (listed in priority order):
  - SHOW_TIME:
    - key != NO_KEY -> KEY_STORED
    - else alarm_button && alarm_sel < NUM_ALARMS -> SHOW_ALARM, latch alarm_idx = alarm_sel
    - else stay
  - KEY_STORED: key != NO_KEY -> KEY_WAITED; else -> KEY_ENTRY. KEY_STORED lasts exactly one cycle, so there is exactly one shift per keypress.
  - KEY_WAITED (waiting for key release):
    - key == NO_KEY -> KEY_ENTRY
    - else tmo -> SHOW_TIME
    - else stay
  - KEY_ENTRY:
    - key != NO_KEY && digit_cnt < NUM_DIGITS -> KEY_STORED
    - key != NO_KEY && digit_cnt == NUM_DIGITS -> KEY_WAITED (no shift; overflow keys are ignored)
    - else alarm_button -> SET_ALARM if digit_cnt == NUM_DIGITS && alarm_sel < NUM_ALARMS (latch alarm_idx); otherwise SHOW_TIME (abort, no load)
    - else time_button -> SET_TIME if digit_cnt == NUM_DIGITS; otherwise SHOW_TIME
    - else tmo -> SHOW_TIME
    - else stay
  - SET_ALARM, SET_TIME: one cycle, then -> SHOW_TIME.
  - SHOW_ALARM: alarm_button -> stay; else -> SHOW_TIME. alarm_sel is ignored while in this state; alarm_idx holds.
- Simultaneous events:
  - Key beats either button.
  - alarm_button beats time_button.
  - Button beats timeout.
  - A one_second tick coincident with a state change is discarded, because the timer clears.
- Timeout latency: after TIMEOUT_SEC ticks seen in the same state, SHOW_TIME is reached on the next clk edge.
- Reset mid-entry abandons the entry: no load strobe, digit_cnt=0.
- Illegal or unused state encodings go to SHOW_TIME on the next clk.

Decomposition:
- Package aclk_pkg:
  - 3-bit state encoding (SHOW_TIME=0, KEY_STORED=1, KEY_WAITED=2, KEY_ENTRY=3, SET_ALARM=4, SET_TIME=5, SHOW_ALARM=6)
  - NO_KEY default
  - clog2 helper function
- Sub-module aclk_entry_timer:
  - Parametrised by TIMEOUT_SEC.
  - Inputs: clk, reset, clr, en, tick.
  - Outputs: tmo.
  - Saturating counter; shared by KEY_WAITED and KEY_ENTRY.

Test Plan:
- Reset mid-KEY_ENTRY with digit_cnt=2 -> next cycle all outputs 0, digit_cnt=0, pstate SHOW_TIME; no load_new_c/load_new_a pulse.
- Defaults; keys 1,2,3,4 each held 3 clk then NO_KEY, then time_button -> exactly 4 single-cycle shift pulses, digit_cnt=4, then one cycle with load_new_c=reset_count=1, then SHOW_TIME.
- Two digits entered, then alarm_button with alarm_sel=1 -> no load_new_a; return to SHOW_TIME next clk; digit_cnt cleared to 0.
- Four digits entered, alarm_sel=1, alarm_button -> load_new_a=1 for one cycle with alarm_idx=1. Separately, a 5th key in KEY_ENTRY produces no shift and digit_cnt stays 4.
- One digit entered, then 10 one_second ticks in KEY_ENTRY -> SHOW_TIME on the clk after the 10th tick, show_new_time drops. Nine ticks then a key -> KEY_STORED, timer restarts from 0.
- alarm_button with alarm_sel=3, NUM_ALARMS=2 -> stays SHOW_TIME. alarm_sel=1 -> show_a=1 with alarm_idx=1 while held; changing alarm_sel while held leaves alarm_idx unchanged.

Source files
------------

// File: rtl/aclk_pkg.sv
// Shared types and helpers for the alarm-clock front-panel controller.
package aclk_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        KEY_STORED = 3'd1,
        KEY_WAITED = 3'd2,
        KEY_ENTRY  = 3'd3,
        SET_ALARM  = 3'd4,
        SET_TIME   = 3'd5,
        SHOW_ALARM = 3'd6
    } state_t;

    localparam int NO_KEY_DEF = 10;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/aclk_entry_timer.sv
// Entry inactivity timer: down-counter loaded with TIMEOUT_SEC, terminal count at zero.
module aclk_entry_timer
    import aclk_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_tick,
    output logic o_tmo
);

    localparam int TW = clog2(TIMEOUT_SEC + 1);
    localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_SEC);

    logic [TW-1:0] r_remain;

    // Holding at zero gives the saturating behaviour of the elapsed-tick count.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_remain <= LOAD_VAL;
        end else if (i_en && i_tick && (r_remain != '0)) begin
            r_remain <= r_remain - TW'(1);
        end
    end

    assign o_tmo = (r_remain == '0);

endmodule

// File: rtl/aclk_ctrl_multi.sv
// Alarm-clock front-panel controller: keypad digit entry, alarm/time display and load strobes.
//   state      | meaning
//   SHOW_TIME  | idle, current time displayed
//   KEY_STORED | one-cycle shift of the pressed key
//   KEY_WAITED | waiting for key release
//   KEY_ENTRY  | waiting for next key or a button
//   SET_ALARM  | one-cycle alarm slot load
//   SET_TIME   | one-cycle time load + prescaler clear
//   SHOW_ALARM | alarm slot displayed while button held
module aclk_ctrl_multi
    import aclk_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TIMEOUT_SEC = 10,
    parameter int NUM_ALARMS  = 2,
    parameter int KEY_W       = 4,
    parameter int NO_KEY      = NO_KEY_DEF,
    localparam int AW = (clog2(NUM_ALARMS) > 1) ? clog2(NUM_ALARMS) : 1,
    localparam int DW = (clog2(NUM_DIGITS + 1) > 1) ? clog2(NUM_DIGITS + 1) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_one_second,
    input  logic             i_alarm_button,
    input  logic             i_time_button,
    input  logic [AW-1:0]    i_alarm_sel,
    input  logic [KEY_W-1:0] i_key,
    output logic             o_shift,
    output logic             o_show_new_time,
    output logic             o_show_a,
    output logic             o_load_new_a,
    output logic             o_load_new_c,
    output logic             o_reset_count,
    output logic [AW-1:0]    o_alarm_idx,
    output logic [DW-1:0]    o_digit_cnt
);

    localparam logic [KEY_W-1:0] NO_KEY_C = KEY_W'(NO_KEY);
    localparam logic [AW:0]      NA_C     = (AW + 1)'(NUM_ALARMS);
    localparam logic [DW-1:0]    ND_C     = DW'(NUM_DIGITS);

    state_t        r_state;
    state_t        w_next;
    logic          r_shift, r_show_new_time, r_show_a, r_load_new_a, r_load_new_c;
    logic [AW-1:0] r_alarm_idx;
    logic [DW-1:0] r_digit_cnt;
    logic          w_key, w_sel_ok, w_full, w_tmo, w_latch_idx, w_timer_en, w_timer_clr;

    assign w_key    = (i_key != NO_KEY_C);
    assign w_sel_ok = ({1'b0, i_alarm_sel} < NA_C);
    assign w_full   = (r_digit_cnt == ND_C);

    always_comb begin
        w_next      = SHOW_TIME;
        w_latch_idx = 1'b0;
        case (r_state)
            SHOW_TIME: begin
                if (w_key) begin
                    w_next = KEY_STORED;
                end else if (i_alarm_button && w_sel_ok) begin
                    w_next      = SHOW_ALARM;
                    w_latch_idx = 1'b1;
                end
            end
            KEY_STORED: w_next = w_key ? KEY_WAITED : KEY_ENTRY;
            KEY_WAITED: begin
                if (!w_key)     w_next = KEY_ENTRY;
                else if (w_tmo) w_next = SHOW_TIME;
                else            w_next = KEY_WAITED;
            end
            KEY_ENTRY: begin
                // Key beats buttons, alarm beats time, any button beats timeout.
                if (w_key) begin
                    w_next = w_full ? KEY_WAITED : KEY_STORED;
                end else if (i_alarm_button) begin
                    if (w_full && w_sel_ok) begin
                        w_next      = SET_ALARM;
                        w_latch_idx = 1'b1;
                    end
                end else if (i_time_button) begin
                    if (w_full) w_next = SET_TIME;
                end else if (!w_tmo) begin
                    w_next = KEY_ENTRY;
                end
            end
            SHOW_ALARM: if (i_alarm_button) w_next = SHOW_ALARM;
            default:    w_next = SHOW_TIME;
        endcase
    end

    assign w_timer_en  = (r_state == KEY_WAITED) || (r_state == KEY_ENTRY);
    assign w_timer_clr = !w_timer_en || (w_next != r_state);

    aclk_entry_timer #(.TIMEOUT_SEC(TIMEOUT_SEC)) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_timer_clr),
        .i_en    (w_timer_en),
        .i_tick  (i_one_second),
        .o_tmo   (w_tmo)
    );

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= SHOW_TIME;
            r_shift         <= 1'b0;
            r_show_new_time <= 1'b0;
            r_show_a        <= 1'b0;
            r_load_new_a    <= 1'b0;
            r_load_new_c    <= 1'b0;
            r_alarm_idx     <= '0;
            r_digit_cnt     <= '0;
        end else begin
            r_state         <= w_next;
            r_shift         <= (w_next == KEY_STORED);
            r_show_new_time <= w_next inside {KEY_STORED, KEY_WAITED, KEY_ENTRY, SET_ALARM, SET_TIME};
            r_show_a        <= (w_next == SHOW_ALARM);
            r_load_new_a    <= (w_next == SET_ALARM);
            r_load_new_c    <= (w_next == SET_TIME);
            if (w_latch_idx) r_alarm_idx <= i_alarm_sel;
            if (w_next == SHOW_TIME) begin
                r_digit_cnt <= '0;
            end else if ((r_state == KEY_STORED) && !w_full) begin
                r_digit_cnt <= r_digit_cnt + DW'(1);
            end
        end
    end

    assign o_shift         = r_shift;
    assign o_show_new_time = r_show_new_time;
    assign o_show_a        = r_show_a;
    assign o_load_new_a    = r_load_new_a;
    assign o_load_new_c    = r_load_new_c;
    assign o_reset_count   = r_load_new_c;
    assign o_alarm_idx     = r_alarm_idx;
    assign o_digit_cnt     = r_digit_cnt;

endmodule
